probe_capture_buf: RTL

PROBE_CAPTURE_BUF -- requirements
Module: probe_capture_buf

---
 rtl/probe_capture_buf.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/probe_capture_buf.sv
// Pre/post-trigger probe capture buffer with a valid/ready readout of the captured window.
// Optional trigger mask port enabled by defining PROBE_CAP_TRIG_MASK_EN.
module probe_capture_buf #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      trig_value,
`ifdef PROBE_CAP_TRIG_MASK_EN
  input  logic [WIDTH-1:0]      trig_mask,
`endif
  input  logic [DEPTH_LOG2-1:0] post_count,
  output logic                  busy,
  output logic                  triggered,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  done
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned FillW = DEPTH_LOG2 + 1;
  localparam logic [FillW-1:0]      FillMax = FillW'(DEPTH);
  localparam logic [FillW-1:0]      FillOne = FillW'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {StIdle, StPre, StPost, StRead} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FillW-1:0]        fill_q, fill_d;
  logic [DEPTH_LOG2-1:0]   post_rem_q, post_rem_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0]        rd_rem_q, rd_rem_d;
  logic                    triggered_q, triggered_d;
  logic [WIDTH-1:0]        rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic                    done_q, done_d;
  logic                    wr_en;
  logic                    hit;
  logic [WIDTH-1:0]        mask;
  logic [WIDTH-1:0]        mem_q [DEPTH];

`ifdef PROBE_CAP_TRIG_MASK_EN
  assign mask = trig_mask;
`else
  assign mask = '1;
`endif

  assign hit = ((data_in ^ trig_value) & mask) == '0;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    post_rem_d  = post_rem_q;
    rd_ptr_d    = rd_ptr_q;
    rd_rem_d    = rd_rem_q;
    triggered_d = triggered_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d     = StPre;
          wr_ptr_d    = '0;
          fill_d      = '0;
          triggered_d = 1'b0;
        end
      end
      StPre, StPost: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrOne;
        if (fill_q != FillMax) fill_d = fill_q + FillOne;
        if (state_q == StPre) begin
          if (hit) begin
            triggered_d = 1'b1;
            post_rem_d  = post_count;
            state_d     = (post_count == '0) ? StRead : StPost;
          end
        end else begin
          post_rem_d = post_rem_q - PtrOne;
          if (post_rem_q == PtrOne) state_d = StRead;
        end
      end
      StRead: begin
        if (rd_valid_q && rd_ready && rd_last_q) begin
          state_d    = StIdle;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          done_d     = 1'b1;
        end else if (!rd_valid_q || rd_ready) begin
          if (rd_rem_q != '0) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_rem_q == FillOne);
            rd_ptr_d   = rd_ptr_q + PtrOne;
            rd_rem_d   = rd_rem_q - FillOne;
          end else begin
            rd_valid_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Oldest entry is the next write slot once the ring has filled, else slot 0.
    if (state_q != StRead && state_d == StRead) begin
      rd_rem_d = fill_d;
      rd_ptr_d = (fill_d == FillMax) ? wr_ptr_d : '0;
    end

    if (abort) begin
      state_d    = StIdle;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      done_d     = 1'b0;
      wr_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_rem_q  <= '0;
      rd_ptr_q    <= '0;
      rd_rem_q    <= '0;
      triggered_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_rem_q  <= post_rem_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_rem_q    <= rd_rem_d;
      triggered_q <= triggered_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

  assign busy      = (state_q != StIdle);
  assign triggered = triggered_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign done      = done_q;

endmodule
